// File: rtl/ctl_pkg.sv
// Shared types and defaults for the ctl_seq instruction sequencer.
package ctl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StMem   = 3'd3,
        StHalt  = 3'd4,
        StErr   = 3'd5
    } ctl_state_t;

    localparam int unsigned TimeoutCyclesDefault = 255;

endpackage

// File: rtl/ctl_seq_if.sv
// Memory handshake and decoder write-enable bundle between ctl_seq and the datapath.
interface ctl_seq_if;

    logic iram_req_o;
    logic iram_ack_i;
    logic inst_latch_en_o;
    logic dram_req_o;
    logic dram_ack_i;
    logic mem_rd_i;
    logic dram_wr_en_i;
    logic pc_wr_en_i;
    logic rd_wr_en_i;
    logic dram_wr_en_o;
    logic pc_wr_en_o;
    logic rd_wr_en_o;

    modport master (
        output iram_req_o,
        input  iram_ack_i,
        output inst_latch_en_o,
        output dram_req_o,
        input  dram_ack_i,
        input  mem_rd_i,
        input  dram_wr_en_i,
        input  pc_wr_en_i,
        input  rd_wr_en_i,
        output dram_wr_en_o,
        output pc_wr_en_o,
        output rd_wr_en_o
    );

    modport slave (
        input  iram_req_o,
        output iram_ack_i,
        input  inst_latch_en_o,
        input  dram_req_o,
        output dram_ack_i,
        output mem_rd_i,
        output dram_wr_en_i,
        output pc_wr_en_i,
        output rd_wr_en_i,
        input  dram_wr_en_o,
        input  pc_wr_en_o,
        input  rd_wr_en_o
    );

endinterface

// File: rtl/ctl_wdt.sv
// Memory-wait watchdog: counts stalled request cycles and flags expiry on the LIMIT-th one.
module ctl_wdt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    // Expiry is combinational so the sequencer leaves the wait state on this very edge.
    assign expire_o = count_i && (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_i && !expire_o) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/ctl_seq.sv
// Multi-cycle fetch/exec/mem sequencer gating decoder write enables to one pulse per retire.
// Optional memory-wait timeout is enabled by defining CTL_SEQ_TIMEOUT_EN.
module ctl_seq
    import ctl_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            halt_i,
    ctl_seq_if.master       bus,
    output logic            halted_o,
    output logic            err_o,
    output logic [XLEN-1:0] instret_o
);

    ctl_state_t      state_q, state_d;
    logic [XLEN-1:0] instret_q;

    logic iram_req, inst_latch, dram_req, dram_wr, pc_wr, rd_wr;
    logic retire;
    logic wait_expire;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StIdle;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + XLEN'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        iram_req   = 1'b0;
        inst_latch = 1'b0;
        dram_req   = 1'b0;
        dram_wr    = 1'b0;
        pc_wr      = 1'b0;
        rd_wr      = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            StIdle: state_d = halt_i ? StHalt : StFetch;
            StFetch: begin
                iram_req = 1'b1;
                if (bus.iram_ack_i) begin
                    inst_latch = 1'b1;
                    state_d    = StExec;
                end else if (wait_expire) begin
                    state_d = StErr;
                end
            end
            StExec: begin
                if (bus.mem_rd_i || bus.dram_wr_en_i) begin
                    state_d = StMem;
                end else begin
                    retire = 1'b1;
                end
            end
            StMem: begin
                dram_req = 1'b1;
                dram_wr  = bus.dram_wr_en_i;
                if (bus.dram_ack_i) begin
                    retire = 1'b1;
                end else if (wait_expire) begin
                    state_d = StErr;
                end
            end
            StHalt: begin
                if (!halt_i) begin
                    state_d = StFetch;
                end
            end
            StErr: state_d = StErr;
            default: state_d = StIdle;
        endcase

        // Retire takes priority; a coincident halt is honoured only after the write strobes.
        if (retire) begin
            pc_wr   = bus.pc_wr_en_i;
            rd_wr   = bus.rd_wr_en_i;
            state_d = halt_i ? StHalt : StFetch;
        end
    end

`ifdef CTL_SEQ_TIMEOUT_EN
    logic wait_clear, wait_count;

    assign wait_clear = (state_d != state_q);
    assign wait_count = (iram_req & ~bus.iram_ack_i) | (dram_req & ~bus.dram_ack_i);

    ctl_wdt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (wait_clear),
        .count_i  (wait_count),
        .expire_o (wait_expire)
    );

    assign err_o = (state_q == StErr);
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wait_expire    = 1'b0;
    assign err_o          = 1'b0;
`endif

    assign bus.iram_req_o      = iram_req;
    assign bus.inst_latch_en_o = inst_latch;
    assign bus.dram_req_o      = dram_req;
    assign bus.dram_wr_en_o    = dram_wr;
    assign bus.pc_wr_en_o      = pc_wr;
    assign bus.rd_wr_en_o      = rd_wr;
    assign halted_o            = (state_q == StHalt);
    assign instret_o           = instret_q;

endmodule

// File: doc/ctl_seq.md
# ctl_seq

Multi-cycle sequencer for the RV32 core datapath. Sits between the instruction decoder, the instruction/data memory ports and the PC/register-file write strobes. Steps each instruction through fetch, execute and optional memory phases with a req/ack handshake on both memories. Gates the decoder's raw write enables so that architectural state changes exactly once per retired instruction.

## Interface
Parameters:
- XLEN, 32, data width; width of the retired-instruction counter.
- TIMEOUT_CYCLES, 255, memory-wait limit; used only with CTL_SEQ_TIMEOUT_EN.

Ports (single clock; reset is asynchronous and active-low):
- clk_i  in  1  core clock.
- rst_n_i  in  1  asynchronous active-low reset.
- halt_i  in  1  debug halt request.
- iram_req_o  out  1  instruction fetch request.
- iram_ack_i  in  1  instruction data valid.
- inst_latch_en_o  out  1  instruction register load strobe.
- dram_req_o  out  1  data memory request.
- dram_ack_i  in  1  data access complete.
- mem_rd_i  in  1  decoded instruction is a load.
- dram_wr_en_i  in  1  decoded store enable.
- pc_wr_en_i  in  1  decoded PC write enable.
- rd_wr_en_i  in  1  decoded rd write enable.
- dram_wr_en_o  out  1  gated store enable.
- pc_wr_en_o  out  1  gated PC write, one pulse per retire.
- rd_wr_en_o  out  1  gated rd write, one pulse per retire.
- halted_o  out  1  core is in HALT.
- err_o  out  1  sticky bus timeout error.
- instret_o  out  XLEN  retired-instruction count.

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT, ERR.
- IDLE: entered on reset. Moves to FETCH on the first clock after reset release.
- FETCH
  - If halt_i=1 on entry, go to HALT instead; no request is issued.
  - Otherwise iram_req_o=1 until iram_ack_i=1.
  - In the ack cycle, inst_latch_en_o=1 and the next state is EXEC.
- EXEC: exactly one cycle.
  - If mem_rd_i or dram_wr_en_i, go to MEM.
  - Otherwise retire: pc_wr_en_o=pc_wr_en_i, rd_wr_en_o=rd_wr_en_i, instret_o+1. Next state is FETCH, or HALT if halt_i=1.
- MEM
  - dram_req_o=1 and dram_wr_en_o=dram_wr_en_i until dram_ack_i=1.
  - In the ack cycle, retire as in EXEC. For a load, rd_wr_en_o pulses in this same cycle.
- HALT: halted_o=1, no requests. Returns to FETCH the cycle after halt_i=0.
- ERR: all requests and strobes are 0, err_o=1. Held until reset.
- Acks received while the matching req is 0 are ignored.
- instret_o wraps modulo 2^XLEN.
- Write strobes are 0 in every state and cycle except the retire cycle. dram_wr_en_o is 0 outside MEM.

## Timing
- Reset (async assert):
  - All outputs are 0 immediately, including instret_o=0 and err_o=0.
  - Any in-flight request is dropped.
  - The state is IDLE.
- Minimum latency:
  - Non-memory instruction: 2 cycles (FETCH with same-cycle ack, then EXEC).
  - Memory instruction: 3 cycles.
- Request outputs are registered-state decodes; ack inputs are sampled on the rising edge.
- halt_i is sampled only at FETCH entry and at retire. It never aborts an outstanding request.
- If halt_i and a retire coincide, the instruction retires first, then the core enters HALT.

## Configuration
- CTL_SEQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle that req=1 and ack=0.
  - When the counter reaches TIMEOUT_CYCLES, the state goes to ERR with no retire.
- CTL_SEQ_TIMEOUT_EN undefined:
  - No counter; waits are unbounded.
  - err_o is tied to 0 and ERR is unreachable.

## Structure
- Shared package ctl_pkg holds:
  - the state enum typedef (ctl_state_t), 3-bit encoding;
  - the TIMEOUT_CYCLES default constant.
- Sub-module ctl_wdt is the wait counter with clear, count and expire outputs. It is instantiated only under CTL_SEQ_TIMEOUT_EN.

## Test plan
- Reset release with iram_ack_i tied 1 and ALU-only instructions:
  - iram_req_o rises on cycle 1.
  - pc_wr_en_o pulses every 2 cycles.
  - instret_o=5 after 10 cycles.
- Load with dram_ack_i delayed 3 cycles:
  - dram_req_o is high for 4 cycles.
  - rd_wr_en_o pulses once, in the ack cycle.
  - dram_wr_en_o stays 0 throughout.
- Store with mem_rd_i=0 and dram_wr_en_i=1:
  - dram_wr_en_o=1 for the whole MEM phase.
  - rd_wr_en_o stays 0.
  - pc_wr_en_o pulses on ack.
- halt_i asserted during EXEC:
  - The instruction retires.
  - halted_o=1 on the next cycle and no iram_req_o is issued.
  - After halt_i deasserts, FETCH resumes one cycle later.
- Timeout (macro on, TIMEOUT_CYCLES=4) with iram_ack_i held 0:
  - err_o=1 after 4 wait cycles.
  - No further requests are issued; rst_n_i low clears err_o.
- rst_n_i pulsed low mid-MEM:
  - dram_req_o drops asynchronously and instret_o=0.
  - The sequence restarts at IDLE.
